// File: rtl/rx_uart_if.sv
// rx_uart_if: serial input and byte-delivery signals of the UART receiver.
// master = receiver side, slave = line driver / byte consumer.
interface rx_uart_if;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_done_signal;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;
  modport master (input rx_in, output rx_data, rx_done_signal, rx_frame_err, rx_parity_err, rx_busy);
  modport slave (output rx_in, input rx_data, rx_done_signal, rx_frame_err, rx_parity_err, rx_busy);
endinterface

// File: rtl/rx_uart.sv
// rx_uart: 8N1 UART receiver, mid-bit sampling on a 2-flop synchronized line.
// Define RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd) and enable rx_parity_err.
module rx_uart #(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int BAUD_RATE = 115200
`ifdef RX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input logic       clk,
  input logic       rst,
  rx_uart_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t             r_state, w_state_n;
  logic [1:0]         r_sync;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift, r_data;
  logic               r_done, r_ferr, r_busy;
  logic               w_rx_s, w_half, w_bit_end, w_cnt_clr, w_shift, w_done, w_ferr;
  assign w_rx_s    = r_sync[1];
  assign w_half    = r_cnt == CNT_W'(HALF_BIT - 1);
  assign w_bit_end = r_cnt == CNT_W'(CLKS_PER_BIT - 1);
`ifdef RX_PARITY_EN
  logic w_par_smp, r_pflag, r_perr;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    w_cnt_clr = 1'b0;
    w_shift   = 1'b0;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
`ifdef RX_PARITY_EN
    w_par_smp = 1'b0;
`endif
    case (r_state)
      IDLE: if (!w_rx_s) begin
        w_state_n = START;
        w_cnt_clr = 1'b1;
      end
      START: if (w_half) begin
        w_state_n = w_rx_s ? IDLE : DATA;
        w_cnt_clr = 1'b1;
      end
      DATA: if (w_bit_end) begin
        w_shift   = 1'b1;
        w_cnt_clr = 1'b1;
`ifdef RX_PARITY_EN
        if (r_idx == 3'd7) w_state_n = PARITY;
`else
        if (r_idx == 3'd7) w_state_n = STOP;
`endif
      end
`ifdef RX_PARITY_EN
      PARITY: if (w_bit_end) begin
        w_par_smp = 1'b1;
        w_cnt_clr = 1'b1;
        w_state_n = STOP;
      end
`endif
      STOP: if (w_bit_end) begin
        w_cnt_clr = 1'b1;
        w_done    = w_rx_s;
        w_ferr    = !w_rx_s;
        w_state_n = w_rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (w_rx_s) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], bus.rx_in};
      r_cnt  <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_shift) begin
        r_idx   <= r_idx + 1'b1;
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
      if (w_done) r_data <= r_shift;
      r_done <= w_done;
      r_ferr <= w_ferr;
      r_busy <= w_state_n != IDLE;
    end
`ifdef RX_PARITY_EN
  // Mismatch is latched at the parity sample and reported alongside the done pulse.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pflag <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_par_smp) r_pflag <= (^r_shift) ^ (PARITY_ODD != 0) ^ w_rx_s;
      r_perr <= w_done & r_pflag;
    end
  assign bus.rx_parity_err = r_perr;
`else
  assign bus.rx_parity_err = 1'b0;
`endif
  assign bus.rx_data        = r_data;
  assign bus.rx_done_signal = r_done;
  assign bus.rx_frame_err   = r_ferr;
  assign bus.rx_busy        = r_busy;
endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: directed and randomized frames against a queue-based byte model of rx_uart.
`timescale 1ns/1ps
module tb_rx_uart;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #2.5 clk = ~clk;
  rx_uart_if bif();
  rx_uart #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (.clk(clk), .rst(rst), .bus(bif));
  int n_vec = 0, n_err = 0, cyc = 0;
  int ferr_cnt = 0, perr_cnt = 0, exp_ferr = 0, exp_perr = 0;
  logic [7:0] exp_q[$], got_q[$];
  int got_cyc[$];
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (!rst) begin
      if (bif.rx_done_signal) begin
        got_q.push_back(bif.rx_data);
        got_cyc.push_back(cyc);
      end
      if (bif.rx_frame_err) ferr_cnt++;
      if (bif.rx_parity_err) perr_cnt++;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic send_bit(input logic b);
    bif.rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef RX_PARITY_EN
    send_bit((^b) ^ par_bad);
    if (stop_ok && par_bad) exp_perr++;
`endif
    send_bit(stop_ok);
    if (stop_ok) exp_q.push_back(b);
    else exp_ferr++;
  endtask
  task automatic check_rx(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_perr"}, perr_cnt, exp_perr);
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bif.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    ferr_cnt = 0; perr_cnt = 0; exp_ferr = 0; exp_perr = 0;
  endtask
  initial begin
    int t0;
    logic [7:0] b;
    bit bad;
    bif.rx_in = 1'b1;
    @(negedge clk);
    do_reset();
    repeat (100) @(negedge clk);
    chk("rst_data", bif.rx_data, 8'h00);
    chk("rst_done", bif.rx_done_signal, 1'b0);
    chk("rst_ferr", bif.rx_frame_err, 1'b0);
    chk("rst_perr", bif.rx_parity_err, 1'b0);
    chk("rst_busy", bif.rx_busy, 1'b0);
    t0 = cyc;
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("f55_latency_ok", (got_cyc.size() > 0) && (got_cyc[0] - t0 >= 152) && (got_cyc[0] - t0 <= 156), 1);
    chk("f55_data", bif.rx_data, 8'h55);
    check_rx("f55");
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("b2b_first", bif.rx_data, 8'hA5);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("b2b_second", bif.rx_data, 8'h3C);
    check_rx("b2b");
    bif.rx_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_hi", bif.rx_busy, 1'b1);
    bif.rx_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_lo", bif.rx_busy, 1'b0);
    check_rx("glitch");
    do_reset();
    send_frame(8'hFF, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("brk_busy", bif.rx_busy, 1'b1);
    chk("brk_data_held", bif.rx_data, 8'h00);
    bif.rx_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("brk_idle", bif.rx_busy, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("brk_next_data", bif.rx_data, 8'h12);
    check_rx("brk");
    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0);
    bif.rx_in = 1'b0;
    repeat (8) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    chk("abort_busy", bif.rx_busy, 1'b0);
    chk("abort_data", bif.rx_data, 8'h00);
    chk("abort_nopulse", got_q.size() + ferr_cnt, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("abort_clean", bif.rx_data, 8'h81);
    check_rx("abort");
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      bad = $urandom_range(0, 7) == 0;
      send_frame(b, !bad, $urandom_range(0, 3) == 0);
      if (bad) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        bif.rx_in = 1'b1;
        repeat (4) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
      end
    end
    repeat (40) @(negedge clk);
    check_rx("rand");
    chk("rand_busy", bif.rx_busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
